// File: rtl/part_2_target_fringe.sv
// Transactor between an initiator handshake and one mission-clocked partition:
// holds an input vector until a mission clock edge, returns the sampled response, and watchdogs idle/stalled periods.
module part_2_target_fringe #(
   parameter int WDOG_MAX = 10000,
   parameter int DATA_W   = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clk_0_h,
   input  logic              rx_valid_i,
   input  logic [DATA_W:0]   rx_data_i,
   output logic              rx_ready_o,
   output logic              tx_valid_o,
   output logic [DATA_W:0]   tx_data_o,
   input  logic              tx_ready_i,
   output logic              wen0_o,
   output logic [DATA_W-1:0] i_data0_o,
   input  logic              sut_valid_i,
   input  logic [DATA_W-1:0] sut_o_data_i,
   output logic              freeze_clk_o,
   output logic              wdog_err_o,
   output logic              missed_edge_o,
   output logic [15:0]       txn_cnt_o
);

   // state     | meaning
   // WAIT_RX   | ready for an initiator vector; armed after the first transaction
   // WAIT_EDGE | vector held on the partition, waiting for a mission clock edge
   // SAMPLE    | capture the partition response
   // SEND      | response offered to the initiator
   // ERR       | watchdog expired; left only through reset
   localparam logic [2:0] WAIT_RX   = 3'd0;
   localparam logic [2:0] WAIT_EDGE = 3'd1;
   localparam logic [2:0] SAMPLE    = 3'd2;
   localparam logic [2:0] SEND      = 3'd3;
   localparam logic [2:0] ERR       = 3'd4;

   localparam logic [15:0] WDOG_LAST = 16'(WDOG_MAX - 1);

   logic [2:0]      state;
   logic [2:0]      state_nxt;
   logic            clk_0_d;
   logic            edge_r;
   logic            armed;
   logic [15:0]     wdog;
   logic            wdog_run;
   logic            wdog_trip;
   logic            accept;
   logic [DATA_W:0] hold;
   logic [DATA_W:0] tx_reg;

   assign accept = (state == WAIT_RX) && rx_valid_i;

   always_comb begin
      state_nxt = state;
      wdog_run  = 1'b0;
      case (state)
         WAIT_RX: begin
            wdog_run = armed;
            if (rx_valid_i) state_nxt = WAIT_EDGE;
         end
         WAIT_EDGE: if (edge_r) state_nxt = SAMPLE;
         SAMPLE:    state_nxt = SEND;
         SEND: begin
            wdog_run = 1'b1;
            if (tx_ready_i) state_nxt = WAIT_RX;
         end
         ERR:       state_nxt = ERR;
         default:   state_nxt = WAIT_RX;
      endcase
      // a state change in the same cycle clears the counter, so it wins over a trip
      wdog_trip = wdog_run && (wdog == WDOG_LAST) && (state_nxt == state);
      if (wdog_trip) state_nxt = ERR;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state         <= WAIT_RX;
         clk_0_d       <= 1'b0;
         edge_r        <= 1'b0;
         armed         <= 1'b0;
         wdog          <= '0;
         hold          <= '0;
         tx_reg        <= '0;
         txn_cnt_o     <= '0;
         wdog_err_o    <= 1'b0;
         missed_edge_o <= 1'b0;
      end else begin
         clk_0_d       <= clk_0_h;
         edge_r        <= clk_0_h & ~clk_0_d;
         state         <= state_nxt;
         missed_edge_o <= edge_r && (state == WAIT_RX) && armed;
         if (state_nxt != state)
            wdog <= '0;
         else if (wdog_run)
            wdog <= wdog + 16'd1;
         if (accept) hold <= rx_data_i;
         if (state == SAMPLE) tx_reg <= {sut_valid_i, sut_o_data_i};
         if ((state == SEND) && tx_ready_i) begin
            armed     <= 1'b1;
            txn_cnt_o <= txn_cnt_o + 16'd1;
         end
         if (wdog_trip) wdog_err_o <= 1'b1;
      end
   end

   assign rx_ready_o   = (state == WAIT_RX);
   assign tx_valid_o   = (state == SEND);
   assign tx_data_o    = tx_reg;
   assign wen0_o       = hold[DATA_W];
   assign i_data0_o    = hold[DATA_W-1:0];
   assign freeze_clk_o = ((state == WAIT_RX) && armed) || (state == SEND) || (state == ERR);

endmodule

// File: tb/tb_part_2_target_fringe.sv
// Directed bench: expected responses go into a queue at stimulus time; a negedge monitor pops them on each tx transfer.
module tb_part_2_target_fringe;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        clk_0_h = 1'b0;
   logic        rx_valid_i = 1'b0;
   logic [8:0]  rx_data_i = '0;
   logic        rx_ready_o;
   logic        tx_valid_o;
   logic [8:0]  tx_data_o;
   logic        tx_ready_i = 1'b0;
   logic        wen0_o;
   logic [7:0]  i_data0_o;
   logic        sut_valid_i = 1'b0;
   logic [7:0]  sut_o_data_i = '0;
   logic        freeze_clk_o;
   logic        wdog_err_o;
   logic        missed_edge_o;
   logic [15:0] txn_cnt_o;

   int          n_vec = 0;
   int          n_err = 0;
   logic [8:0]  exp_q[$];

   part_2_target_fringe #(.WDOG_MAX(16), .DATA_W(8)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .clk_0_h       (clk_0_h),
      .rx_valid_i    (rx_valid_i),
      .rx_data_i     (rx_data_i),
      .rx_ready_o    (rx_ready_o),
      .tx_valid_o    (tx_valid_o),
      .tx_data_o     (tx_data_o),
      .tx_ready_i    (tx_ready_i),
      .wen0_o        (wen0_o),
      .i_data0_o     (i_data0_o),
      .sut_valid_i   (sut_valid_i),
      .sut_o_data_i  (sut_o_data_i),
      .freeze_clk_o  (freeze_clk_o),
      .wdog_err_o    (wdog_err_o),
      .missed_edge_o (missed_edge_o),
      .txn_cnt_o     (txn_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #100000;
      $display("FAIL timeout: simulation limit reached");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // monitor: scoreboard pops on transfer, and a stalled offer must persist unchanged
   logic       prev_stall = 1'b0;
   logic [8:0] prev_data = '0;
   always @(negedge clk_i) begin
      if (rst_i) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            n_vec++;
            if (tx_valid_o !== 1'b1 || tx_data_o !== prev_data) begin
               n_err++;
               $display("FAIL tx_hold: got valid=%0b data=0x%0h expected valid=1 data=0x%0h",
                        tx_valid_o, tx_data_o, prev_data);
            end
         end
         if (tx_valid_o && tx_ready_i) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL tx_unexpected: got 0x%0h expected no transfer", tx_data_o);
            end else begin
               logic [8:0] e;
               e = exp_q.pop_front();
               if (tx_data_o !== e) begin
                  n_err++;
                  $display("FAIL tx_data: got 0x%0h expected 0x%0h", tx_data_o, e);
               end
            end
         end
         prev_stall = tx_valid_o && !tx_ready_i;
         prev_data  = tx_data_o;
      end
   end

   task automatic send_vec(input logic [8:0] rxd, input logic sv, input logic [7:0] sd,
                           input int stall, input bit finish, input logic [15:0] exp_cnt);
      check("rx_ready_pre", 32'(rx_ready_o), 32'd1);
      rx_valid_i = 1'b1;
      rx_data_i  = rxd;
      tick();
      rx_valid_i = 1'b0;
      rx_data_i  = '0;
      check("wen0", 32'(wen0_o), 32'(rxd[8]));
      check("i_data0", 32'(i_data0_o), 32'(rxd[7:0]));
      check("rx_ready_busy", 32'(rx_ready_o), 32'd0);
      sut_valid_i  = sv;
      sut_o_data_i = sd;
      if (finish) exp_q.push_back({sv, sd});
      clk_0_h = 1'b1;
      tick();
      tick();
      check("lat_early", 32'(tx_valid_o), 32'd0);
      tick();
      check("lat_2", 32'(tx_valid_o), 32'd1);
      check("freeze_send", 32'(freeze_clk_o), 32'd1);
      clk_0_h      = 1'b0;
      sut_valid_i  = 1'b0;
      sut_o_data_i = '0;
      repeat (stall) tick();
      if (finish) begin
         tx_ready_i = 1'b1;
         tick();
         tx_ready_i = 1'b0;
         check("txn_cnt", 32'(txn_cnt_o), 32'(exp_cnt));
         check("freeze_armed", 32'(freeze_clk_o), 32'd1);
         check("rx_ready_post", 32'(rx_ready_o), 32'd1);
      end
   endtask

   initial begin
      repeat (2) tick();
      check("rst_rx_ready", 32'(rx_ready_o), 32'd1);
      check("rst_tx_valid", 32'(tx_valid_o), 32'd0);
      check("rst_tx_data", 32'(tx_data_o), 32'd0);
      check("rst_wen0", 32'(wen0_o), 32'd0);
      check("rst_i_data0", 32'(i_data0_o), 32'd0);
      check("rst_freeze", 32'(freeze_clk_o), 32'd0);
      check("rst_wdog_err", 32'(wdog_err_o), 32'd0);
      check("rst_missed", 32'(missed_edge_o), 32'd0);
      check("rst_txn_cnt", 32'(txn_cnt_o), 32'd0);
      rst_i = 1'b0;
      tick();
      check("freeze_unarmed", 32'(freeze_clk_o), 32'd0);

      send_vec(9'h1A5, 1'b1, 8'h3C, 0, 1'b1, 16'd1);
      send_vec(9'h05A, 1'b0, 8'hFF, 5, 1'b1, 16'd2);
      send_vec(9'h1FF, 1'b1, 8'h00, 2, 1'b1, 16'd3);

      // armed with no vector held: edge is reported, not consumed
      clk_0_h = 1'b1;
      tick();
      tick();
      check("missed_pulse", 32'(missed_edge_o), 32'd1);
      check("missed_rx_ready", 32'(rx_ready_o), 32'd1);
      clk_0_h = 1'b0;
      tick();
      check("missed_end", 32'(missed_edge_o), 32'd0);
      check("missed_no_tx", 32'(tx_valid_o), 32'd0);

      // reset while a response is on offer
      send_vec(9'h1C3, 1'b1, 8'h77, 3, 1'b0, 16'd0);
      rst_i = 1'b1;
      tick();
      check("rst_send_tx_valid", 32'(tx_valid_o), 32'd0);
      check("rst_send_txn_cnt", 32'(txn_cnt_o), 32'd0);
      check("rst_send_wdog_err", 32'(wdog_err_o), 32'd0);
      check("rst_send_wen0", 32'(wen0_o), 32'd0);
      check("rst_send_freeze", 32'(freeze_clk_o), 32'd0);
      rst_i = 1'b0;
      tick();

      // idle while armed until the watchdog expires
      send_vec(9'h111, 1'b1, 8'h42, 0, 1'b1, 16'd1);
      repeat (9) tick();
      check("wdog_early", 32'(wdog_err_o), 32'd0);
      check("wdog_early_ready", 32'(rx_ready_o), 32'd1);
      repeat (10) tick();
      check("wdog_err", 32'(wdog_err_o), 32'd1);
      check("err_rx_ready", 32'(rx_ready_o), 32'd0);
      check("err_tx_valid", 32'(tx_valid_o), 32'd0);
      check("err_freeze", 32'(freeze_clk_o), 32'd1);
      rx_valid_i = 1'b1;
      rx_data_i  = 9'h0AA;
      tick();
      rx_valid_i = 1'b0;
      rx_data_i  = '0;
      check("err_ignore_rx_ready", 32'(rx_ready_o), 32'd0);
      check("err_hold_wen0", 32'(wen0_o), 32'd1);
      check("err_hold_data", 32'(i_data0_o), 32'h11);
      check("err_sticky", 32'(wdog_err_o), 32'd1);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      tick();
      check("err_cleared", 32'(wdog_err_o), 32'd0);
      check("err_rx_ready_back", 32'(rx_ready_o), 32'd1);

      repeat (2) tick();
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
